// File: rtl/mmu_utlb_pkg.sv
// Shared definitions for the micro-TLB MMU: segment codes, the K0 cacheable
// encoding, the uTLB entry layout and the walk FSM states.
package mmu_utlb_pkg;

  // vaddr[31:29] segment codes; kuseg is 3'b0xx.
  localparam logic [2:0] SegKseg0 = 3'b100;
  localparam logic [2:0] SegKseg1 = 3'b101;
  localparam logic [2:0] SegKseg2 = 3'b110;
  localparam logic [2:0] SegKseg3 = 3'b111;

  // Config.K0 value selecting cacheable kseg0 accesses.
  localparam logic [2:0] K0Cacheable = 3'd3;

  // VPN/PFN are stored right-aligned in 32-bit fields so the layout does not
  // depend on the page size; unused upper bits are always zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] vpn;
    logic [31:0] pfn;
    logic        cached;
    logic        dirty;
  } utlb_entry_t;

  typedef enum logic {
    StIdle = 1'b0,
    StWalk = 1'b1
  } walk_state_e;

  // Unmapped segments, plus every mapped segment while Status.ERL is set.
  function automatic logic seg_unmapped(input logic [2:0] seg, input logic erl);
    case (seg)
      SegKseg0, SegKseg1: return 1'b1;
      SegKseg2, SegKseg3: return erl;
      default:            return erl;
    endcase
  endfunction

endpackage

// File: rtl/utlb_array.sv
// Fully-associative uTLB storage: parallel compare, hit select, FIFO fill
// pointer and whole-array flush. Flush has priority over a same-cycle fill.
module utlb_array
  import mmu_utlb_pkg::*;
#(
  parameter int unsigned Entries = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lookup_vpn_i,
  input  logic        lookup_store_i,
  output logic        hit_o,
  output utlb_entry_t hit_entry_o,
  input  logic        fill_i,
  input  utlb_entry_t fill_entry_i,
  input  logic        flush_i
);

  localparam int unsigned IdxW = (Entries > 1) ? $clog2(Entries) : 1;

  utlb_entry_t     entries_q [Entries];
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] hit_idx;

  // Parallel compare; a store to a clean page is a miss so the walk reports tlbm.
  always_comb begin
    hit_o   = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < Entries; i++) begin
      if (entries_q[i].valid && (entries_q[i].vpn == lookup_vpn_i) &&
          !(lookup_store_i && !entries_q[i].dirty)) begin
        hit_o   = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
    hit_entry_o = entries_q[hit_idx];
  end

  // Entry storage with round-robin replacement; the pointer wraps naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        entries_q[i] <= '0;
      end
      ptr_q <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else if (fill_i) begin
      entries_q[ptr_q] <= fill_entry_i;
      ptr_q            <= ptr_q + IdxW'(1);
    end
  end

endmodule

// File: rtl/mmu_utlb.sv
// TLB-based MMU with a micro-TLB in front of the shared main TLB. Unmapped
// segments and uTLB hits translate in the same cycle; misses walk the main
// TLB and refill the uTLB, then the replayed access hits.
// Optional MMU_UTLB_PERF_EN adds saturating hit/miss counters.
module mmu_utlb
  import mmu_utlb_pkg::*;
#(
  parameter int unsigned UTLB_ENTRIES = 4,
  parameter int unsigned PAGE_BITS    = 12,
  parameter int unsigned PA_BITS      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         wen,
  input  logic [31:0]        vaddr,
  input  logic               exc_flag,
  input  logic               flush,
  input  logic               cp0_status_erl,
  input  logic [2:0]         cp0_config_k0,
  output logic               tlb_en,
  output logic [31:0]        tlb_vaddr,
  output logic               tlb_refs,
  input  logic               tlb_rdy,
  input  logic [31:0]        tlb_paddr,
  input  logic               tlb_cat,
  input  logic               tlb_dirty,
  input  logic               tlb_tlbr,
  input  logic               tlb_tlbi,
  input  logic               tlb_tlbm,
  output logic               bus_en,
  output logic [PA_BITS-1:0] bus_paddr,
  output logic               bus_cached,
  output logic               exc_tlbr,
  output logic               exc_tlbi,
  output logic               exc_tlbm,
  output logic               stallreq
`ifdef MMU_UTLB_PERF_EN
  ,
  output logic [31:0]        perf_hit,
  output logic [31:0]        perf_miss
`endif
);

  localparam int unsigned VpnW = 32 - PAGE_BITS;

  walk_state_e state_q;
  logic        discard_q;

  logic [2:0]  seg;
  logic        unmapped;
  logic        is_store;
  logic        k0_cached;
  logic [31:0] lookup_vpn;
  logic [31:0] unmapped_pa;
  logic [31:0] pa32;
  logic [63:0] pa_ext;
  logic        hit;
  utlb_entry_t hit_entry;
  utlb_entry_t fill_entry;
  logic        fill;
  logic        start_walk;
  logic        unused_bits;

  assign seg         = vaddr[31:29];
  assign unmapped    = seg_unmapped(seg, cp0_status_erl);
  assign is_store    = |wen;
  assign k0_cached   = (seg == SegKseg0) && (cp0_config_k0 == K0Cacheable);
  assign lookup_vpn  = 32'(vaddr[31:PAGE_BITS]);
  assign unmapped_pa = {3'b000, vaddr[28:0]};

  assign fill_entry.valid  = 1'b1;
  assign fill_entry.vpn    = lookup_vpn;
  assign fill_entry.pfn    = 32'(tlb_paddr[31:PAGE_BITS]);
  assign fill_entry.cached = tlb_cat;
  assign fill_entry.dirty  = tlb_dirty;

  utlb_array #(
    .Entries(UTLB_ENTRIES)
  ) u_array (
    .clk_i         (clk),
    .rst_i         (rst),
    .lookup_vpn_i  (lookup_vpn),
    .lookup_store_i(is_store),
    .hit_o         (hit),
    .hit_entry_o   (hit_entry),
    .fill_i        (fill),
    .fill_entry_i  (fill_entry),
    .flush_i       (flush)
  );

  // Output muxing; combinational so hits and unmapped accesses cost no cycle.
  // Everything is held low while rst is asserted.
  always_comb begin
    tlb_en     = 1'b0;
    tlb_vaddr  = vaddr;
    tlb_refs   = is_store;
    bus_en     = 1'b0;
    bus_cached = 1'b0;
    pa32       = unmapped_pa;
    exc_tlbr   = 1'b0;
    exc_tlbi   = 1'b0;
    exc_tlbm   = 1'b0;
    stallreq   = 1'b0;
    fill       = 1'b0;
    start_walk = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (unmapped) begin
            bus_en     = en && !exc_flag;
            bus_cached = k0_cached;
          end else if (en) begin
            if (hit) begin
              pa32       = {hit_entry.pfn[VpnW-1:0], vaddr[PAGE_BITS-1:0]};
              bus_cached = hit_entry.cached;
              bus_en     = !exc_flag;
            end else begin
              stallreq   = 1'b1;
              tlb_en     = 1'b1;
              start_walk = 1'b1;
            end
          end
        end
        StWalk: begin
          if (en) begin
            tlb_en   = 1'b1;
            stallreq = 1'b1;
            // A result overlapping a flush is stale: drop it and keep stalling.
            if (tlb_rdy && !discard_q && !flush) begin
              if (tlb_tlbr || tlb_tlbi || tlb_tlbm) begin
                exc_tlbr = tlb_tlbr;
                exc_tlbi = tlb_tlbi;
                exc_tlbm = tlb_tlbm;
                stallreq = 1'b0;
              end else begin
                fill = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pa_ext    = {32'd0, pa32};
  assign bus_paddr = pa_ext[PA_BITS-1:0];

  // Walk FSM; every WALK exit returns to IDLE, which replays or restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      discard_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          discard_q <= 1'b0;
          if (start_walk) state_q <= StWalk;
        end
        StWalk: begin
          if (!en || tlb_rdy) begin
            state_q   <= StIdle;
            discard_q <= 1'b0;
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MMU_UTLB_PERF_EN
  logic        hit_evt;
  logic [31:0] perf_hit_q;
  logic [31:0] perf_miss_q;

  assign hit_evt = !rst && (state_q == StIdle) && !unmapped && en && hit;

  // Saturating event counters, cleared together with the uTLB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else if (flush) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      if (hit_evt && (perf_hit_q != '1)) perf_hit_q <= perf_hit_q + 32'd1;
      if (start_walk && (perf_miss_q != '1)) perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`endif

  assign unused_bits = ^{hit_entry, tlb_paddr[PAGE_BITS-1:0], pa_ext};

endmodule

// File: tb/tb_mmu_utlb.sv
// Scoreboard bench for mmu_utlb: the driver pushes each access's expected bus
// result or exception, and a negedge monitor pops whenever the DUT shows one.
module tb_mmu_utlb;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] vaddr;
  logic        exc_flag;
  logic        flush;
  logic        cp0_status_erl;
  logic [2:0]  cp0_config_k0;
  logic        tlb_en;
  logic [31:0] tlb_vaddr;
  logic        tlb_refs;
  logic        tlb_rdy;
  logic [31:0] tlb_paddr;
  logic        tlb_cat;
  logic        tlb_dirty;
  logic        tlb_tlbr;
  logic        tlb_tlbi;
  logic        tlb_tlbm;
  logic        bus_en;
  logic [31:0] bus_paddr;
  logic        bus_cached;
  logic        exc_tlbr;
  logic        exc_tlbi;
  logic        exc_tlbm;
  logic        stallreq;
`ifdef MMU_UTLB_PERF_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  mmu_utlb #(
    .UTLB_ENTRIES(4),
    .PAGE_BITS   (12),
    .PA_BITS     (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .wen           (wen),
    .vaddr         (vaddr),
    .exc_flag      (exc_flag),
    .flush         (flush),
    .cp0_status_erl(cp0_status_erl),
    .cp0_config_k0 (cp0_config_k0),
    .tlb_en        (tlb_en),
    .tlb_vaddr     (tlb_vaddr),
    .tlb_refs      (tlb_refs),
    .tlb_rdy       (tlb_rdy),
    .tlb_paddr     (tlb_paddr),
    .tlb_cat       (tlb_cat),
    .tlb_dirty     (tlb_dirty),
    .tlb_tlbr      (tlb_tlbr),
    .tlb_tlbi      (tlb_tlbi),
    .tlb_tlbm      (tlb_tlbm),
    .bus_en        (bus_en),
    .bus_paddr     (bus_paddr),
    .bus_cached    (bus_cached),
    .exc_tlbr      (exc_tlbr),
    .exc_tlbi      (exc_tlbi),
    .exc_tlbm      (exc_tlbm),
    .stallreq      (stallreq)
`ifdef MMU_UTLB_PERF_EN
    ,
    .perf_hit      (perf_hit),
    .perf_miss     (perf_miss)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_exc;
    logic [31:0] pa;
    logic        cached;
    logic [2:0]  exc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic expect_ok(input logic [31:0] pa, input logic c);
    exp_t e;
    e.is_exc = 1'b0;
    e.pa     = pa;
    e.cached = c;
    e.exc    = 3'b000;
    sb.push_back(e);
  endtask

  task automatic expect_exc(input logic [2:0] x);
    exp_t e;
    e.is_exc = 1'b1;
    e.pa     = '0;
    e.cached = 1'b0;
    e.exc    = x;
    sb.push_back(e);
  endtask

  // Monitor: every bus access or exception must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus_en || exc_tlbr || exc_tlbi || exc_tlbm)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got paddr %h exc %b, expected no output",
                 bus_paddr, {exc_tlbr, exc_tlbi, exc_tlbm});
      end else begin
        e = sb.pop_front();
        if (e.is_exc) begin
          check("mon.exc_bits", 32'({exc_tlbr, exc_tlbi, exc_tlbm}), 32'(e.exc));
          check("mon.exc_bus_en", 32'(bus_en), 32'd0);
        end else begin
          check("mon.paddr", bus_paddr, e.pa);
          check("mon.cached", 32'(bus_cached), 32'(e.cached));
          check("mon.no_exc", 32'({exc_tlbr, exc_tlbi, exc_tlbm}), 32'd0);
        end
      end
    end
  end

  // One access with a main-TLB model that answers 'lat' cycles after each
  // request; flush_rdy asserts flush together with the first answer.
  task automatic run(input string nm, input logic [31:0] va, input logic [3:0] we,
                     input int lat, input logic [31:0] pa, input logic cat,
                     input logic dirty, input logic [2:0] flt, input logic flush_rdy,
                     input int exp_stalls);
    int   stalls    = 0;
    int   t         = 0;
    int   rdys      = 0;
    logic done      = 1'b0;
    logic en_seen   = 1'b0;
    logic refs_seen = 1'b0;
    @(posedge clk);
    #1;
    en        = 1'b1;
    vaddr     = va;
    wen       = we;
    tlb_paddr = pa;
    tlb_cat   = cat;
    tlb_dirty = dirty;
    {tlb_tlbr, tlb_tlbi, tlb_tlbm} = flt;
    tlb_rdy   = 1'b0;
    flush     = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (tlb_en) begin
        en_seen = 1'b1;
        if (tlb_refs) refs_seen = 1'b1;
      end
      if (!stallreq) done = 1'b1;
      else stalls++;
      if (tlb_en) t = tlb_rdy ? 0 : t + 1;
      @(posedge clk);
      #1;
      tlb_rdy = !done && (t == lat);
      if (tlb_rdy) rdys++;
      flush = tlb_rdy && flush_rdy && (rdys == 1);
    end
    en      = 1'b0;
    wen     = 4'h0;
    tlb_rdy = 1'b0;
    flush   = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got stall beyond 40 cycles, expected completion", nm);
    end
    check({nm, ".stalls"}, 32'(stalls), 32'(exp_stalls));
    check({nm, ".tlb_en_seen"}, 32'(en_seen), 32'(exp_stalls > 0));
    check({nm, ".tlb_refs"}, 32'(refs_seen), 32'((we != 4'h0) && (exp_stalls > 0)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    en             = 1'b0;
    wen            = 4'h0;
    vaddr          = 32'h0040_0000;
    exc_flag       = 1'b0;
    flush          = 1'b0;
    cp0_status_erl = 1'b0;
    cp0_config_k0  = 3'd3;
    tlb_rdy        = 1'b0;
    tlb_paddr      = '0;
    tlb_cat        = 1'b0;
    tlb_dirty      = 1'b0;
    {tlb_tlbr, tlb_tlbi, tlb_tlbm} = 3'b000;

    @(negedge clk);
    check("reset.outputs", 32'({tlb_en, stallreq, bus_en, exc_tlbr, exc_tlbi, exc_tlbm}),
          32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Unmapped segments.
    expect_ok(32'h0000_1234, 1'b1);
    run("kseg0", 32'h8000_1234, 4'h0, 1, '0, 1'b0, 1'b0, 3'b000, 1'b0, 0);
    expect_ok(32'h0000_1234, 1'b0);
    run("kseg1", 32'hA000_1234, 4'h0, 1, '0, 1'b0, 1'b0, 3'b000, 1'b0, 0);
    cp0_config_k0 = 3'd2;
    expect_ok(32'h1FFF_FFFC, 1'b0);
    run("kseg0_k0_uncached", 32'h9FFF_FFFC, 4'h0, 1, '0, 1'b0, 1'b0, 3'b000, 1'b0, 0);
    cp0_config_k0 = 3'd3;

    // Cold miss (lat 3) then zero-stall hit in the same page.
    expect_ok(32'h1234_5010, 1'b1);
    run("cold_miss", 32'h0040_0010, 4'h0, 3, 32'h1234_5010, 1'b1, 1'b1, 3'b000, 1'b0, 4);
    expect_ok(32'h1234_5FFC, 1'b1);
    run("page_hit", 32'h0040_0FFC, 4'h0, 1, '0, 1'b0, 1'b0, 3'b000, 1'b0, 0);

    // ERL makes mapped segments kseg1-style.
    cp0_status_erl = 1'b1;
    expect_ok(32'h0040_0010, 1'b0);
    run("erl_kuseg", 32'h0040_0010, 4'h0, 1, '0, 1'b0, 1'b0, 3'b000, 1'b0, 0);
    expect_ok(32'h0000_0010, 1'b0);
    run("erl_kseg2", 32'hC000_0010, 4'h0, 1, '0, 1'b0, 1'b0, 3'b000, 1'b0, 0);
    cp0_status_erl = 1'b0;

    // exc_flag gates bus_en on unmapped and hit paths without stalling.
    @(posedge clk);
    #1;
    exc_flag = 1'b1;
    en       = 1'b1;
    vaddr    = 32'h8000_0040;
    @(negedge clk);
    check("excflag_unmapped", 32'({bus_en, stallreq}), 32'd0);
    @(posedge clk);
    #1 vaddr = 32'h0040_0004;
    @(negedge clk);
    check("excflag_hit", 32'({bus_en, stallreq}), 32'd0);
    @(posedge clk);
    #1;
    en       = 1'b0;
    exc_flag = 1'b0;

    // Pages 1..4 fill entries 1,2,3 then wrap to entry 0 (evicting page 0).
    for (int k = 1; k <= 4; k++) begin
      expect_ok(32'h2000_0000 | (k << 12), 1'b1);
      run("fifo_fill", 32'h0040_0000 | (k << 12), 4'h0, 1, 32'h2000_0000 | (k << 12),
          1'b1, 1'b1, 3'b000, 1'b0, 2);
    end
    expect_ok(32'h2000_1010, 1'b1);
    run("fifo_keep", 32'h0040_1010, 4'h0, 1, '0, 1'b0, 1'b0, 3'b000, 1'b0, 0);
    expect_ok(32'h1234_5020, 1'b1);
    run("fifo_evicted", 32'h0040_0020, 4'h0, 1, 32'h1234_5000, 1'b1, 1'b1, 3'b000, 1'b0, 2);

    // Store to a clean page walks with tlb_refs and gets tlbm; no fill.
    expect_ok(32'h3000_5000, 1'b0);
    run("clean_fill", 32'h0040_5000, 4'h0, 1, 32'h3000_5000, 1'b0, 1'b0, 3'b000, 1'b0, 2);
    expect_exc(3'b001);
    run("store_clean", 32'h0040_5004, 4'hF, 1, 32'h3000_5000, 1'b0, 1'b0, 3'b001, 1'b0, 1);
    @(negedge clk);
    check("tlbm_pulse", 32'({exc_tlbr, exc_tlbi, exc_tlbm}), 32'd0);
    expect_ok(32'h3000_5008, 1'b0);
    run("clean_load_hit", 32'h0040_5008, 4'h0, 1, '0, 1'b0, 1'b0, 3'b000, 1'b0, 0);

    // Faults never fill: the retry after tlbi misses again.
    expect_exc(3'b010);
    run("tlbi_fault", 32'h0040_6000, 4'h0, 1, 32'h3000_6000, 1'b1, 1'b1, 3'b010, 1'b0, 1);
    expect_ok(32'h3000_6000, 1'b1);
    run("after_fault", 32'h0040_6000, 4'h0, 1, 32'h3000_6000, 1'b1, 1'b1, 3'b000, 1'b0, 2);
    expect_exc(3'b100);
    run("tlbr_fault", 32'h0040_9000, 4'h0, 2, '0, 1'b0, 1'b0, 3'b100, 1'b0, 2);

    // Flush with tlb_rdy: result dropped, walk repeats, old entries gone.
    expect_ok(32'h4000_7000, 1'b1);
    run("flush_rdy", 32'h0040_7000, 4'h0, 2, 32'h4000_7000, 1'b1, 1'b1, 3'b000, 1'b1, 6);
    expect_ok(32'h3000_5008, 1'b0);
    run("after_flush", 32'h0040_5008, 4'h0, 1, 32'h3000_5000, 1'b0, 1'b0, 3'b000, 1'b0, 2);
    expect_ok(32'h4000_7008, 1'b1);
    run("store_dirty_hit", 32'h0040_7008, 4'h1, 1, '0, 1'b0, 1'b0, 3'b000, 1'b0, 0);

    // Reset mid-walk: handshake drops at once and the uTLB is emptied.
    @(posedge clk);
    #1;
    en    = 1'b1;
    vaddr = 32'h0040_8000;
    @(negedge clk);
    check("rst_walk.start", 32'(stallreq), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_walk.walking", 32'(tlb_en), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_walk.drop", 32'({tlb_en, stallreq}), 32'd0);
    @(posedge clk);
    #1;
    en  = 1'b0;
    rst = 1'b0;
    expect_ok(32'h4000_7004, 1'b1);
    run("after_rst", 32'h0040_7004, 4'h0, 1, 32'h4000_7000, 1'b1, 1'b1, 3'b000, 1'b0, 2);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
